// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, sign fix-up into HI/LO.
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_zero_o
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state;
    state_t state_nxt;

    logic                div_q;
    logic                s1_q;
    logic                s2_q;
    logic                dz_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [CW-1:0]       cnt_q;

    logic              neg1;
    logic              neg2;
    logic [DATA_W-1:0] mag1;
    logic [DATA_W-1:0] mag2;
    logic              dz_in;

    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_nxt;
    logic [DATA_W:0]     div_r;
    logic                div_ge;
    logic [DATA_W:0]     div_d;
    logic [2*DATA_W-1:0] div_nxt;

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quot;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   src1_raw;

    assign neg1  = op_i[0] & src1_i[DATA_W-1];
    assign neg2  = op_i[0] & src2_i[DATA_W-1];
    assign mag1  = neg1 ? -src1_i : src1_i;
    assign mag2  = neg2 ? -src2_i : src2_i;
    assign dz_in = op_i[1] & (src2_i == '0);

    // One shift-add step (LSB first) and one restoring-divide step (MSB first).
    always_comb begin
        mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                + {1'b0, (b_q[0] ? a_q : '0)};
        mul_nxt = {mul_sum, acc_q[DATA_W-1:1]};
        div_r   = {acc_q[2*DATA_W-1:DATA_W], a_q[DATA_W-1]};
        div_ge  = div_r >= {1'b0, b_q};
        div_d   = div_ge ? div_r - {1'b0, b_q} : div_r;
        div_nxt = {div_d[DATA_W-1:0], acc_q[DATA_W-2:0], div_ge};
    end

    // Sign correction of the unsigned magnitude results.
    always_comb begin
        prod     = (s1_q ^ s2_q) ? -acc_q : acc_q;
        quot     = (s1_q ^ s2_q) ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem      = s1_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        src1_raw = s1_q ? -a_q : a_q;
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; divide by zero bypasses the iterations.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_i) state_nxt = dz_in ? FIX : RUN;
            RUN:  if (cnt_q == LAST) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered results.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q      <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            dz_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            div_zero_o <= 1'b0;
        end else begin
            busy_o <= (state_nxt != IDLE);
            done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        div_q <= op_i[1];
                        s1_q  <= neg1;
                        s2_q  <= neg2;
                        dz_q  <= dz_in;
                        a_q   <= mag1;
                        b_q   <= mag2;
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (div_q) begin
                        acc_q <= div_nxt;
                        a_q   <= a_q << 1;
                    end else begin
                        acc_q <= mul_nxt;
                        b_q   <= b_q >> 1;
                    end
                end
                FIX: begin
                    done_o     <= 1'b1;
                    div_zero_o <= dz_q;
                    if (dz_q) begin
                        hi_o <= src1_raw;
                        lo_o <= '1;
                    end else if (div_q) begin
                        hi_o <= rem;
                        lo_o <= quot;
                    end else begin
                        hi_o <= prod[2*DATA_W-1:DATA_W];
                        lo_o <= prod[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit.
// Directed literal cases plus randomized ops against a behavioural model.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    mul_div_unit #(.DATA_W(32)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference result {div_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        logic [63:0] u;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (op)
            2'b00: begin
                u = {32'b0, a} * {32'b0, b};
                return {1'b0, u};
            end
            2'b01: begin
                p = sa * sb;
                return {1'b0, 64'(p)};
            end
            default: begin
                if (b == 32'b0) return {1'b1, a, 32'hFFFFFFFF};
                if (op == 2'b10) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
        endcase
    endfunction

    logic        m_busy;
    logic        m_done;
    logic        m_dz;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [64:0] m_pend;
    int          m_left;

    // Behavioural model: result appears a fixed number of cycles after accept.
    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_pend <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && start_i) begin
                m_pend <= ref_op(op_i, src1_i, src2_i);
                m_busy <= 1'b1;
                m_left <= (op_i[1] && src2_i == 32'b0) ? 1 : 33;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_dz, m_hi, m_lo} <= m_pend;
                end
                m_left <= m_left - 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc busy", {31'b0, busy_o}, {31'b0, m_busy});
            chk("cyc done", {31'b0, done_o}, {31'b0, m_done});
            chk("cyc hi", hi_o, m_hi);
            chk("cyc lo", lo_o, m_lo);
            chk("cyc dz", {31'b0, div_zero_o}, {31'b0, m_dz});
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
    endtask

    task automatic wait_done(input bit hold, output int lat,
                             output int bcnt);
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (busy_o) bcnt++;
            if (done_o) break;
            if (!hold) start_i = 1'b0;
            src1_i = $urandom;
            src2_i = $urandom;
        end
        chk("done seen", {31'b0, done_o}, 32'd1);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh,
                       input logic [31:0] el, input logic edz,
                       input int elat, input string nm);
        int lat;
        int bc;
        issue(op, a, b);
        wait_done(1'b0, lat, bc);
        chk({nm, " latency"}, lat, elat);
        chk({nm, " busy cycles"}, bc, elat - 1);
        chk({nm, " hi"}, hi_o, eh);
        chk({nm, " lo"}, lo_o, el);
        chk({nm, " dz"}, {31'b0, div_zero_o}, {31'b0, edz});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int bc;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_i   = 1'b0;
        start_i = 1'b0;
        op_i    = 2'b00;
        src1_i  = '0;
        src2_i  = '0;
        #1;
        chk("reset busy", {31'b0, busy_o}, 32'd0);
        chk("reset done", {31'b0, done_o}, 32'd0);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        chk("reset dz", {31'b0, div_zero_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_i  = 1'b1;
        cmp_en = 1'b1;

        run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 0, 34,
            "multu max");
        run(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 34,
            "mult -3x7");
        run(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, 34,
            "mult minxmin");
        run(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34, "divu 100/7");
        run(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34,
            "div -7/2");
        run(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 34,
            "div min/-1");
        run(2'b11, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 1, 2,
            "div by zero");
        run(2'b10, 32'd9, 32'd3, 32'd0, 32'd3, 0, 34, "divu 9/3");

        issue(2'b01, 32'hFFFFFFFD, 32'd7);
        wait_done(1'b1, lat, bc);
        chk("hold latency", lat, 34);
        chk("hold hi", hi_o, 32'hFFFFFFFF);
        chk("hold lo", lo_o, 32'hFFFFFFEB);
        op_i   = 2'b00;
        src1_i = 32'd6;
        src2_i = 32'd7;
        @(negedge clk);
        chk("b2b busy", {31'b0, busy_o}, 32'd1);
        chk("b2b done low", {31'b0, done_o}, 32'd0);
        start_i = 1'b0;
        wait_done(1'b0, lat, bc);
        chk("b2b latency", lat, 33);
        chk("b2b lo", lo_o, 32'd42);
        chk("b2b hi", hi_o, 32'd0);

        issue(2'b01, 32'h00012345, 32'hFFFF0001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        #2 rst_i = 1'b0;
        #1;
        chk("abort busy", {31'b0, busy_o}, 32'd0);
        chk("abort done", {31'b0, done_o}, 32'd0);
        chk("abort hi", hi_o, 32'd0);
        chk("abort lo", lo_o, 32'd0);
        chk("abort dz", {31'b0, div_zero_o}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("no done after abort", {31'b0, done_o}, 32'd0);
        end
        run(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 0, 34, "multu 6x7");

        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            issue(rop, ra, rb);
            wait_done(1'b0, lat, bc);
            chk("rand latency", lat, (rop[1] && rb == 32'b0) ? 2 : 34);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit in the execute stage, beside the ALU. It takes the same register-file operands the ALU receives and computes MULT/MULTU/DIV/DIVU over 33 clock cycles. Results go into HI/LO registers, which feed the execute-stage result mux alongside the ALU's result_o for mfhi/mflo. The control unit stalls the pipeline while busy_o is high.

## Interface
- DATA_W, 32, operand and result width (block verified at 32 only)
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous reset, active-low
- start_i  input  1  request; accepted only when state is IDLE
- op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start
- src1_i  input  DATA_W  multiplicand / dividend; sampled with start
- src2_i  input  DATA_W  multiplier / divisor; sampled with start
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle completion pulse
- hi_o  output  DATA_W  HI: product[63:32] or remainder
- lo_o  output  DATA_W  LO: product[31:0] or quotient
- div_zero_o  output  1  last completed op was a divide by zero

## Operation
- States: IDLE, RUN, FIX.
- IDLE + start_i=1:
  - latch op, magnitude of each operand, and sign flags;
  - clear the 64-bit accumulator and the 5-bit count;
  - go to RUN.
- Magnitude and sign rules:
  - For signed ops, magnitude = two's-complement absolute value; 0x80000000 stays 0x80000000, treated as unsigned 2^31.
  - For unsigned ops, sign flags = 0.
- Divide by zero: IDLE + start + op[1]=1 + src2_i==0 goes directly to FIX and skips RUN.
- RUN performs one iteration per cycle; count increments; after count==31 go to FIX.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first; 64-bit unsigned product.
  - Divide: restoring, one quotient bit per cycle, MSB first; 32-bit unsigned quotient and remainder.
- FIX applies sign correction, writes hi_o/lo_o, pulses done_o, returns to IDLE.
  - MULT: negate the 64-bit product if sign1^sign2.
  - DIV: negate quotient if sign1^sign2; negate remainder if sign1.
  - MULTU/DIVU: no correction.
  - Divide by zero: lo_o=0xFFFFFFFF, hi_o=src1 as latched, div_zero_o=1.
  - Every other completion sets div_zero_o=0.
- DIV 0x80000000 / 0xFFFFFFFF gives lo_o=0x80000000, hi_o=0. This falls out of the magnitude path; no trap.
- hi_o, lo_o, div_zero_o hold their value until the next FIX. They are unchanged while RUN is in progress.
- start_i in RUN or FIX is ignored; there is no queueing.
- Reset values (asynchronous, on rst_i low): state IDLE, busy_o=0, done_o=0, hi_o=0, lo_o=0, div_zero_o=0, internal accumulator and count 0.
- Reset mid-operation aborts it; no done_o is issued.

## Timing
- Edge numbering: the edge that accepts start is edge 0.
- Normal op:
  - RUN iterations occur on edges 1..32.
  - FIX registers the results on edge 33.
  - busy_o is 1 after edge 0 through edge 33 and drops after edge 33.
  - done_o=1 and hi_o/lo_o are valid in the cycle after edge 33; done_o returns to 0 after edge 34.
- Divide by zero: results are registered on edge 1; done_o is high in the cycle after edge 1; busy_o is high only between edges 0 and 1.
- Back-to-back: start_i high in the done_o cycle is accepted on edge 34 (state is IDLE). busy_o rises the same edge done_o falls.
- Operand inputs may change freely after edge 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001, done_o exactly 34 cycles after start, busy_o high for 33 cycles.
- MULT 0xFFFFFFFD (-3) × 7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; then MULT 0x80000000 × 0x80000000 -> hi_o=0x40000000, lo_o=0.
- DIVU 100 / 7 -> lo_o=14, hi_o=2; DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIV 0x12345678 / 0 -> done_o 2 cycles after start, lo_o=0xFFFFFFFF, hi_o=0x12345678, div_zero_o=1; a following DIVU 9/3 clears div_zero_o, lo_o=3, hi_o=0.
- start_i held high with changing operands during RUN -> ignored, result matches the first operands; start in the done_o cycle accepted and busy_o rises with no gap.
- rst_i low at cycle 10 of a MULT -> all outputs 0 immediately, no done_o; after release, MULTU 6×7 -> lo_o=42, hi_o=0.
